song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Play-side responder to the menu/state controller.
- Accepts a confirmed song number and steps through that song's fixed note pattern one beat at a time.
- Drives the three lane bits to the LED-matrix renderer, scores player button hits, and returns `finish` to the state controller when the song ends.
- Sits between the state controller and the LED matrix driver.

Parameters:
- TICKS_PER_BEAT, 25000000: clk cycles per beat (range 2..2^26-1).
- SONG1_LEN, 16: beats in song 1 (range 1..63).
- SONG2_LEN, 24: beats in song 2.
- SONG3_LEN, 32: beats in song 3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- state  in  2  controller state: 0 START, 1 MENU, 2 PLAY, 3 FINISH.
- song_confirm  in  2  one-cycle pulse with song number 1..3; 0 means none.
- red_button  in  1  lane 0 button, level.
- blue_button  in  1  lane 1 button, level.
- yellow_button  in  1  lane 2 button, level.
- finish  out  1  song complete; level.
- note_lanes  out  3  notes expected in the current beat; bit0 red, bit1 blue, bit2 yellow.
- beat_idx  out  6  current beat number.
- song_id  out  2  song being played; 0 when none has been loaded.
- score  out  8  hits in the current or last song; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): all of the following are 0 and the FSM is in IDLE:
  - outputs: finish, note_lanes, beat_idx, song_id, score
  - internal registers: tick counter, previous-button register, hit_mask
- FSM states: IDLE, PLAY, DONE.
- IDLE:
  - Load when state==1 and song_confirm!=0.
  - Load action, next edge: song_id<=song_confirm, beat_idx<=0, tick<=0, score<=0, hit_mask<=0, go to PLAY.
  - song_confirm is ignored in every state other than IDLE.
- PLAY:
  - Tick counter counts 0..TICKS_PER_BEAT-1.
  - On the edge where tick==TICKS_PER_BEAT-1: tick<=0, hit_mask<=0, and one of:
    - if beat_idx==LEN(song_id)-1: go to DONE, finish<=1;
    - else beat_idx<=beat_idx+1.
- note_lanes is combinational from (song_id, beat_idx), and is 0 outside PLAY:
  - song 1: 3'b001 << (beat_idx mod 3).
  - song 2: beat_idx[0] ? 3'b010 : 3'b101.
  - song 3: beat_idx[2:0]==0 ? 3'b111 : beat_idx[2:0].
- Hit detection:
  - Buttons are registered each cycle. Rising edge = current 1 and previous 0, evaluated per lane.
  - An edge on lane k in PLAY with note_lanes[k]=1 and hit_mask[k]=0 sets hit_mask[k] and counts as a hit.
  - Score adds the number of hits in that cycle (0..3), saturating at 255.
  - Presses on empty lanes or already-hit lanes: no change.
- Beat-boundary cycle:
  - Edges are scored against the old beat's note_lanes.
  - hit_mask is then cleared regardless.
  - On the final beat's boundary the hit still counts.
- DONE:
  - finish held at 1, note_lanes=0, beat_idx holds its last value.
  - When state==3: finish<=0, go to IDLE.
  - score and song_id hold until the next load.
- Abort: if state is 0 or 1 while in PLAY or DONE (state input lags by one cycle after load, so this check is skipped in the first PLAY cycle):
  - Go to IDLE next edge, finish<=0, score held.
- Reset mid-song: immediate return to the reset values.

Optional Feature:
- Macro: SONG_SEQ_COUNTIN_EN.
- Defined:
  - A load enters COUNTIN state instead of PLAY.
  - COUNTIN lasts 4 beats of TICKS_PER_BEAT cycles, with note_lanes=3'b111 on count beats 0 and 2 and 0 otherwise.
  - No scoring during COUNTIN; beat_idx stays 0.
  - COUNTIN then goes to PLAY with tick=0.
  - Abort rules apply in COUNTIN.
- Undefined: COUNTIN does not exist; load goes directly to PLAY.

Test Plan (TICKS_PER_BEAT=4, SONG1_LEN=16, SONG2_LEN=24, SONG3_LEN=32, macro undefined unless stated):
- Reset release, state=1, song_confirm=1 for one cycle → next cycle song_id=1, beat_idx=0, note_lanes=001; after 4 clks beat_idx=1, note_lanes=010.
- Song 1 with no presses → finish rises 64 clks after load, score=0; finish drops the cycle after state=3 is driven.
- Song 2, red edge in beat 0 (lanes 101), then red held and re-pressed within the same beat → score=1; yellow edge in the same beat → score=2; blue edge → score unchanged.
- Red and yellow rise together on a beat-2 boundary cycle of song 2 → score +2, and the next beat (lanes 010) starts with hit_mask=0.
- state forced to 1 at beat 5 of song 3 → IDLE next edge, finish never asserted, note_lanes=0, score retained; song_confirm during PLAY ignored.
- SONG_SEQ_COUNTIN_EN defined, load song 3 → 16 clks of count-in (lanes 111 in clks 0-3 and 8-11), then beat_idx=0, note_lanes=111; rst pulse at any point → all outputs 0.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Signal bundle between the menu/state controller, the player buttons and song_sequencer.
// song_confirm is a one-cycle strobe. It is taken only while the sequencer is idle and
// state==MENU. There is no back-pressure, and every output is a level.
interface song_sequencer_if;
    logic [1:0] state;
    logic [1:0] song_confirm;
    logic       red_button;
    logic       blue_button;
    logic       yellow_button;
    logic       finish;
    logic [2:0] note_lanes;
    logic [5:0] beat_idx;
    logic [1:0] song_id;
    logic [7:0] score;
    logic [1:0] fsm_state;

    modport master (
        output state, song_confirm, red_button, blue_button, yellow_button,
        input  finish, note_lanes, beat_idx, song_id, score, fsm_state
    );

    modport slave (
        input  state, song_confirm, red_button, blue_button, yellow_button,
        output finish, note_lanes, beat_idx, song_id, score, fsm_state
    );
endinterface

// File: rtl/song_sequencer.sv
// Steps a confirmed song's note pattern beat by beat, scores button hits and flags song end.
// Define SONG_SEQ_COUNTIN_EN to insert a 4-beat count-in between load and play.
module song_sequencer #(
    parameter int TICKS_PER_BEAT = 25000000,
    parameter int SONG1_LEN      = 16,
    parameter int SONG2_LEN      = 24,
    parameter int SONG3_LEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    song_sequencer_if.slave  bus
);

    localparam logic [1:0]  CTRL_START  = 2'd0;
    localparam logic [1:0]  CTRL_MENU   = 2'd1;
    localparam logic [1:0]  CTRL_FINISH = 2'd3;
    localparam logic [25:0] TICK_LAST   = 26'(TICKS_PER_BEAT - 1);

`ifdef SONG_SEQ_COUNTIN_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_DONE    = 2'd2,
        S_COUNTIN = 2'd3
    } fsm_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } fsm_t;
`endif

    fsm_t        state_q;
    fsm_t        state_d;
    logic [25:0] tick_q;
    logic [5:0]  beat_q;
    logic [1:0]  song_q;
    logic [7:0]  score_q;
    logic [2:0]  hit_mask_q;
    logic [2:0]  btn_prev_q;
    logic        finish_q;
    logic        fresh_q;
`ifdef SONG_SEQ_COUNTIN_EN
    logic [1:0]  count_q;
`endif

    logic [2:0]  btn_now;
    logic [2:0]  btn_rise;
    logic [2:0]  song_lanes;
    logic [2:0]  lanes;
    logic [2:0]  hits;
    logic [1:0]  hit_cnt;
    logic [8:0]  score_sum;
    logic [7:0]  score_next;
    logic [5:0]  last_beat;
    logic        tick_last;
    logic        ticking;
    logic        load_req;
    logic        abort_req;

    assign btn_now   = {bus.yellow_button, bus.blue_button, bus.red_button};
    assign btn_rise  = btn_now & ~btn_prev_q;
    assign tick_last = (tick_q == TICK_LAST);
    assign load_req  = (state_q == S_IDLE) && (bus.state == CTRL_MENU) &&
                       (bus.song_confirm != 2'd0);
    // The controller's state input trails a load by one cycle, so the first cycle after a load never aborts.
    assign abort_req = !fresh_q &&
                       ((bus.state == CTRL_START) || (bus.state == CTRL_MENU));

`ifdef SONG_SEQ_COUNTIN_EN
    assign ticking = (state_q == S_PLAY) || (state_q == S_COUNTIN);
`else
    assign ticking = (state_q == S_PLAY);
`endif

    always_comb begin
        song_lanes = 3'b000;
        case (song_q)
            2'd1:    song_lanes = 3'b001 << (beat_q % 6'd3);
            2'd2:    song_lanes = beat_q[0] ? 3'b010 : 3'b101;
            2'd3:    song_lanes = (beat_q[2:0] == 3'd0) ? 3'b111 : beat_q[2:0];
            default: song_lanes = 3'b000;
        endcase
    end

    always_comb begin
        lanes = 3'b000;
        if (state_q == S_PLAY) begin
            lanes = song_lanes;
        end
`ifdef SONG_SEQ_COUNTIN_EN
        else if ((state_q == S_COUNTIN) && !count_q[0]) begin
            lanes = 3'b111;
        end
`endif
    end

    always_comb begin
        last_beat = 6'd0;
        case (song_q)
            2'd1:    last_beat = 6'(SONG1_LEN - 1);
            2'd2:    last_beat = 6'(SONG2_LEN - 1);
            2'd3:    last_beat = 6'(SONG3_LEN - 1);
            default: last_beat = 6'd0;
        endcase
    end

    // Edges on a boundary cycle still score against the outgoing beat's lanes.
    assign hits       = (state_q == S_PLAY) ? (btn_rise & song_lanes & ~hit_mask_q) : 3'b000;
    assign hit_cnt    = {1'b0, hits[0]} + {1'b0, hits[1]} + {1'b0, hits[2]};
    assign score_sum  = {1'b0, score_q} + {7'd0, hit_cnt};
    assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
`ifdef SONG_SEQ_COUNTIN_EN
                    state_d = S_COUNTIN;
`else
                    state_d = S_PLAY;
`endif
                end
            end
            S_PLAY: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (tick_last && (beat_q == last_beat)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (abort_req || (bus.state == CTRL_FINISH)) begin
                    state_d = S_IDLE;
                end
            end
`ifdef SONG_SEQ_COUNTIN_EN
            S_COUNTIN: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (tick_last && (count_q == 2'd3)) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q     <= '0;
            beat_q     <= '0;
            song_q     <= '0;
            score_q    <= '0;
            hit_mask_q <= '0;
            btn_prev_q <= '0;
            finish_q   <= 1'b0;
            fresh_q    <= 1'b0;
`ifdef SONG_SEQ_COUNTIN_EN
            count_q    <= '0;
`endif
        end else begin
            btn_prev_q <= btn_now;
            fresh_q    <= load_req;
            if (load_req) begin
                song_q     <= bus.song_confirm;
                beat_q     <= '0;
                tick_q     <= '0;
                score_q    <= '0;
                hit_mask_q <= '0;
                finish_q   <= 1'b0;
`ifdef SONG_SEQ_COUNTIN_EN
                count_q    <= '0;
`endif
            end else begin
                if (state_q == S_PLAY) begin
                    score_q    <= score_next;
                    hit_mask_q <= tick_last ? 3'b000 : (hit_mask_q | hits);
                end
                if (state_d == S_IDLE) begin
                    tick_q   <= '0;
                    finish_q <= 1'b0;
                end else if (ticking) begin
                    tick_q <= tick_last ? 26'd0 : tick_q + 26'd1;
                end
                if ((state_q == S_PLAY) && (state_d == S_PLAY) && tick_last) begin
                    beat_q <= beat_q + 6'd1;
                end
                if ((state_q == S_PLAY) && (state_d == S_DONE)) begin
                    finish_q <= 1'b1;
                end
`ifdef SONG_SEQ_COUNTIN_EN
                if ((state_q == S_COUNTIN) && tick_last) begin
                    count_q <= count_q + 2'd1;
                end
`endif
            end
        end
    end

    assign bus.finish     = finish_q;
    assign bus.note_lanes = lanes;
    assign bus.beat_idx   = beat_q;
    assign bus.song_id    = song_q;
    assign bus.score      = score_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomised scoreboard bench for song_sequencer: a rule-level model predicts every cycle's outputs.
// Also honours SONG_SEQ_COUNTIN_EN when the bench and the design are built with it defined.
module tb_song_sequencer;
    localparam int T  = 4;
    localparam int L1 = 16;
    localparam int L2 = 24;
    localparam int L3 = 32;
`ifdef SONG_SEQ_COUNTIN_EN
    localparam int CI = 4 * T;
`else
    localparam int CI = 0;
`endif
    localparam int PH_IDLE  = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_DONE  = 2;
    localparam int PH_COUNT = 3;

    logic clk;
    logic rst;
    song_sequencer_if bus ();

    song_sequencer #(
        .TICKS_PER_BEAT(T),
        .SONG1_LEN(L1),
        .SONG2_LEN(L2),
        .SONG3_LEN(L3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    logic [19:0] mon_act;

    // Reference model state: cycles since the load, plus the lanes already hit in each beat.
    int       m_phase;
    int       m_cyc;
    int       m_song;
    int       m_score;
    int       m_beat;
    bit       m_fin;
    bit       m_fresh;
    logic [2:0] m_prev;
    logic [2:0] m_taken[64];

    function automatic int len_of(input int song);
        case (song)
            1:       return L1;
            2:       return L2;
            3:       return L3;
            default: return 1;
        endcase
    endfunction

    function automatic int lanes_of(input int song, input int beat);
        case (song)
            1: begin
                case (beat % 3)
                    0:       return 1;
                    1:       return 2;
                    default: return 4;
                endcase
            end
            2:       return (beat % 2 == 1) ? 2 : 5;
            3:       return (beat % 8 == 0) ? 7 : (beat % 8);
            default: return 0;
        endcase
    endfunction

    function automatic logic [19:0] snapshot();
        int l;
        l = 0;
        if (m_phase == PH_PLAY) l = lanes_of(m_song, m_cyc / T);
        if (m_phase == PH_COUNT) l = ((m_cyc / T) % 2 == 0) ? 7 : 0;
        return {m_fin, 3'(l), 6'(m_beat), 2'(m_song), 8'(m_score)};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_cyc   = 0;
        m_song  = 0;
        m_score = 0;
        m_beat  = 0;
        m_fin   = 1'b0;
        m_fresh = 1'b0;
        m_prev  = 3'b000;
        for (int i = 0; i < 64; i++) m_taken[i] = 3'b000;
    endtask

    task automatic model_step(input int st, input int conf, input logic [2:0] btn);
        logic [2:0] edges;
        logic [2:0] hits;
        bit         was_fresh;
        bit         abort;
        int         beat;
        edges     = btn & ~m_prev;
        m_prev    = btn;
        was_fresh = m_fresh;
        m_fresh   = 1'b0;
        abort     = !was_fresh && (st == 0 || st == 1);
        case (m_phase)
            PH_IDLE: begin
                if (st == 1 && conf != 0) begin
                    m_song  = conf;
                    m_cyc   = 0;
                    m_score = 0;
                    m_beat  = 0;
                    for (int i = 0; i < 64; i++) m_taken[i] = 3'b000;
                    m_phase = (CI > 0) ? PH_COUNT : PH_PLAY;
                    m_fresh = 1'b1;
                end
            end
            PH_PLAY: begin
                beat = m_cyc / T;
                hits = edges & 3'(lanes_of(m_song, beat)) & ~m_taken[beat];
                m_taken[beat] = m_taken[beat] | hits;
                m_score = m_score + $countones(hits);
                if (m_score > 255) m_score = 255;
                if (abort) begin
                    m_phase = PH_IDLE;
                    m_beat  = beat;
                end else begin
                    m_cyc = m_cyc + 1;
                    if (m_cyc == len_of(m_song) * T) begin
                        m_phase = PH_DONE;
                        m_fin   = 1'b1;
                        m_beat  = len_of(m_song) - 1;
                    end else begin
                        m_beat = m_cyc / T;
                    end
                end
            end
            PH_DONE: begin
                if (abort || st == 3) begin
                    m_phase = PH_IDLE;
                    m_fin   = 1'b0;
                end
            end
            default: begin
                if (abort) begin
                    m_phase = PH_IDLE;
                end else begin
                    m_cyc = m_cyc + 1;
                    if (m_cyc == 4 * T) begin
                        m_phase = PH_PLAY;
                        m_cyc   = 0;
                    end
                end
            end
        endcase
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard queue.
    task automatic cycle(input int st, input int conf, input int btn);
        logic [19:0] e;
        bus.state         = 2'(st);
        bus.song_confirm  = 2'(conf);
        bus.red_button    = btn[0];
        bus.blue_button   = btn[1];
        bus.yellow_button = btn[2];
        model_step(st, conf, 3'(btn));
        e = snapshot();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst               = 1'b0;
        bus.state         = 2'd0;
        bus.song_confirm  = 2'd0;
        bus.red_button    = 1'b0;
        bus.blue_button   = 1'b0;
        bus.yellow_button = 1'b0;
        #1;
        check_val("reset_outputs",
                  int'({bus.finish, bus.note_lanes, bus.beat_idx, bus.song_id, bus.score, bus.fsm_state}), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.finish, bus.note_lanes, bus.beat_idx, bus.song_id, bus.score};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t actual fin=%0d lanes=%b beat=%0d song=%0d score=%0d required fin=%0d lanes=%b beat=%0d song=%0d score=%0d",
                         $time, mon_act[19], mon_act[18:16], mon_act[15:10], mon_act[9:8], mon_act[7:0],
                         mon_exp[19], mon_exp[18:16], mon_exp[15:10], mon_exp[9:8], mon_exp[7:0]);
            end
        end
    end

    int fin_at;
    int song;
    int abort_at;
    int n;

    initial begin
        rst = 1'b0;
        model_reset();
        do_reset();
        cycle(0, 0, 0);
        cycle(1, 0, 0);

        // Song 1, no presses: load latency, beat stepping and finish timing.
        cycle(1, 1, 0);
        check_val("load_song_id", int'(bus.song_id), 1);
        check_val("load_beat_idx", int'(bus.beat_idx), 0);
        check_val("load_note_lanes", int'(bus.note_lanes), (CI == 0) ? 1 : 7);
        fin_at = -1;
        for (int k = 1; k <= 90; k++) begin
            cycle((k == 1) ? 1 : 2, 0, 0);
            if (k == 4) begin
                check_val("beat1_idx", int'(bus.beat_idx), (CI == 0) ? 1 : 0);
                check_val("beat1_lanes", int'(bus.note_lanes), (CI == 0) ? 2 : 0);
            end
            if (bus.finish && fin_at < 0) fin_at = k;
        end
        check_val("finish_latency", fin_at, 64 + CI);
        check_val("song1_score", int'(bus.score), 0);
        cycle(3, 0, 0);
        check_val("finish_drop", int'(bus.finish), 0);

        // Song 2: repeated presses within a beat and a press on the beat boundary.
        cycle(1, 0, 0);
        cycle(1, 2, 0);
        repeat (CI) cycle(2, 0, 0);
        cycle(2, 0, 3'b001);
        cycle(2, 0, 3'b101);
        cycle(2, 0, 3'b100);
        cycle(2, 0, 3'b111);
        check_val("song2_beat0_score", int'(bus.score), 2);
        repeat (7) cycle(2, 0, 0);
        cycle(2, 0, 3'b101);
        check_val("boundary_score", int'(bus.score), 4);
        check_val("boundary_next_lanes", int'(bus.note_lanes), 2);
        cycle(2, 0, 3'b010);
        check_val("beat3_blue_score", int'(bus.score), 5);
        n = 0;
        while (m_phase != PH_DONE && n < 200) begin
            n++;
            cycle(2, 0, $urandom_range(0, 7));
        end
        check_val("song2_reached_done", int'(bus.finish), 1);
        cycle(3, 0, 0);

        // Song 3: a confirm during play is ignored, then the controller drops back to MENU at beat 5.
        cycle(1, 0, 0);
        cycle(1, 3, 0);
        repeat (CI) cycle(2, 0, 0);
        repeat (8) cycle(2, 0, $urandom_range(0, 7));
        cycle(2, 1, 0);
        repeat (11) cycle(2, 0, $urandom_range(0, 7));
        cycle(2, 0, 0);
        cycle(1, 2, 0);
        check_val("abort_finish", int'(bus.finish), 0);
        check_val("abort_lanes", int'(bus.note_lanes), 0);
        check_val("abort_song_id", int'(bus.song_id), 3);
        check_val("abort_beat_idx", int'(bus.beat_idx), 5);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check_val("abort_finish_stays_low", int'(bus.finish), 0);

        // Random songs with random presses, aborts and exits from DONE.
        for (int r = 0; r < 10; r++) begin
            song = $urandom_range(1, 3);
            abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len_of(song) * T + CI + 3) : -1;
            cycle(1, 0, 0);
            cycle(1, song, 0);
            n = 0;
            while (m_phase != PH_IDLE && n < 300) begin
                n++;
                if (n == abort_at)
                    cycle($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
                else if (m_phase == PH_DONE && $urandom_range(0, 2) == 0)
                    cycle(($urandom_range(0, 1) == 0) ? 3 : 0, 0, 0);
                else
                    cycle(2, $urandom_range(0, 3), $urandom_range(0, 7));
            end
            check_val("random_run_ends", int'(n < 300), 1);
        end

        // Reset in the middle of a song, then recover with a fresh load.
        cycle(1, 0, 0);
        cycle(1, 2, 0);
        repeat (CI + 10) cycle(2, 0, $urandom_range(0, 7));
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        repeat (CI + 8) cycle(2, 0, $urandom_range(0, 7));

        @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
